// File: rtl/key_debounce_capture.sv
// key_debounce_capture
// Synchronises, debounces and counts presses on up to four push-buttons and
// packs the result into the 32-bit word polled by the host through the button
// PIO. Layout of buttons_out:
//   [N_KEYS-1:0]     debounced pressed level per key
//   [19+4i:16+4i]    4-bit wrapping press counter of key i
//   all other bits   0
module key_debounce_capture #(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit KEYS_ACTIVE_LOW = 1'b1
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [31:0]       buttons_out,
   output logic [N_KEYS-1:0] press_pulse
);

   // The counter only has to reach DEBOUNCE_CYCLES-1, the cycle on which the
   // new level is accepted.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Raw pin level of a released key; XOR with it turns "pressed" into 1.
   localparam logic [N_KEYS-1:0] RELEASED_RAW = {N_KEYS{KEYS_ACTIVE_LOW}};

   logic [N_KEYS-1:0] sync1_q, sync1_d;
   logic [N_KEYS-1:0] sync2_q, sync2_d;
   logic [N_KEYS-1:0] stable_q, stable_d;
   logic [N_KEYS-1:0] press_pulse_q, press_pulse_d;
   logic [CNT_W-1:0]  deb_cnt_q [N_KEYS];
   logic [CNT_W-1:0]  deb_cnt_d [N_KEYS];
   logic [3:0]        presses_q [N_KEYS];
   logic [3:0]        presses_d [N_KEYS];
   logic [31:0]       buttons_out_q, buttons_out_d;
   logic [N_KEYS-1:0] key_norm;

   // Two-flop synchroniser on the raw asynchronous pins.
   always_comb begin
      sync1_d = key_in;
      sync2_d = sync1_q;
   end

   // Per-key debounce: a level that disagrees with the accepted state for
   // DEBOUNCE_CYCLES consecutive cycles becomes the new accepted state; a
   // release-to-press acceptance bumps the press counter and fires the strobe.
   always_comb begin
      key_norm = sync2_q ^ RELEASED_RAW;
      for (int i = 0; i < N_KEYS; i++) begin
         stable_d[i]      = stable_q[i];
         deb_cnt_d[i]     = '0;
         presses_d[i]     = presses_q[i];
         press_pulse_d[i] = 1'b0;
         if (key_norm[i] != stable_q[i]) begin
            if (deb_cnt_q[i] == CNT_LAST) begin
               stable_d[i] = ~stable_q[i];
               if (!stable_q[i]) begin
                  presses_d[i]     = presses_q[i] + 4'd1;
                  press_pulse_d[i] = 1'b1;
               end
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Pack the next-state values so the host word changes on the same edge
   // as the accepted level.
   always_comb begin
      buttons_out_d = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         buttons_out_d[i]            = stable_d[i];
         buttons_out_d[16+4*i +: 4]  = presses_d[i];
      end
   end

   // State registers; reset returns everything to the released, idle state.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sync1_q       <= RELEASED_RAW;
         sync2_q       <= RELEASED_RAW;
         stable_q      <= '0;
         press_pulse_q <= '0;
         buttons_out_q <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_q[i] <= '0;
            presses_q[i] <= '0;
         end
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         press_pulse_q <= press_pulse_d;
         buttons_out_q <= buttons_out_d;
         for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
            presses_q[i] <= presses_d[i];
         end
      end
   end

   assign buttons_out = buttons_out_q;
   assign press_pulse = press_pulse_q;

endmodule

// File: doc/key_debounce_capture.md
Name: key_debounce_capture

Overview:
- Conditions the raw push-button inputs before they reach the 32-bit button PIO input word (in_bottoms) of the PCIe host system.
- Each button passes through a two-flop synchronizer and a per-key debounce filter. A 4-bit press counter per key records completed presses.
- The host polls the word and detects presses by watching the counters change, so no press is lost between polls.
- The block sits in the board top level, between the KEY pins and the PCIe core's button input.

Parameters:
- N_KEYS, 4, number of buttons; legal range 1..4.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz); must be >= 1.
- KEYS_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board KEYs); 0 = pin reads 1 when pressed.

Ports:
- clk_clk  input  1  system clock, the same clock as the PCIe core's PIO domain.
- reset_reset_n  input  1  synchronous active-low reset.
- key_in  input  N_KEYS  raw asynchronous button pins.
- buttons_out  output  32  word fed to in_bottoms_external_connection_export.
- press_pulse  output  N_KEYS  one-cycle strobe per accepted press, for local LED or debug use.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-low: it is sampled only on the rising edge of clk_clk, while reset_reset_n = 0.
- Reset values:
  - Synchronizer flops are loaded with the released level: 1 when KEYS_ACTIVE_LOW = 1, else 0.
  - Debounce counters are 0.
  - Stable state of every key is released (0).
  - Press counters are 0.
  - press_pulse = 0 and buttons_out = 32'h0000_0000.
- Normalisation:
  - Raw value = key_in XOR {N_KEYS{KEYS_ACTIVE_LOW}}. Pressed is 1 after normalisation.
  - Normalisation is applied after the second synchronizer flop.
- Debounce, per key and independent of the other keys:
  - When sync2 equals stable, the counter clears to 0.
  - When sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - When sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, stable toggles at this edge and the counter clears.
  - A mismatch that lasts fewer than DEBOUNCE_CYCLES cycles produces no change.
- Latency:
  - A clean input change at edge 0 appears on sync2 after edge 2.
  - stable flips at edge 2+DEBOUNCE_CYCLES.
  - buttons_out and press_pulse are driven directly from registers, so they change at that same edge.
- Press event:
  - A stable 0->1 transition increments that key's counter modulo 16 (15 wraps to 0).
  - press_pulse[i] is 1 for exactly one cycle at that transition.
  - A release (1->0) changes neither the counter nor press_pulse.
- Output layout:
  - buttons_out[i] = stable[i] for i < N_KEYS.
  - Bits [15:N_KEYS] = 0.
  - buttons_out[19+4i:16+4i] = press counter i for i < N_KEYS.
  - All remaining bits = 0.
- Simultaneous events:
  - Keys accepted in the same cycle each update their own counter and pulse in that cycle.
- Reset during operation:
  - All state is cleared, including any debounce in progress.
  - A key held through reset is seen as a new press: after release of reset it re-qualifies and increments its counter, 2+DEBOUNCE_CYCLES edges later.
- Outputs never go X after reset.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4, KEYS_ACTIVE_LOW=1, N_KEYS=4:
  - Stimulus: after reset, key_in = 4'b1110 at edge 0 and held.
  - Required: buttons_out = 32'h0001_0001 from edge 6; press_pulse = 4'b0001 for exactly one cycle.
- Glitch rejection:
  - Stimulus: key_in[1] low for 3 cycles, then high.
  - Required: buttons_out stays 32'h0; press_pulse stays 0.
- Release and re-press:
  - Stimulus: press key2, release, press again, each held at least 10 cycles.
  - Required: bit 2 follows 1, 0, 1; field [27:24] goes 1 then 2; only 2 pulses on press_pulse[2].
- Counter wrap plus simultaneous keys:
  - Stimulus: 16 clean presses of key0 and key3 together.
  - Required: fields [19:16] and [31:28] step 1..15 then 0 in lockstep; both pulses coincide every time.
- Reset mid-debounce and held through reset:
  - Stimulus: key1 low for 2 cycles, assert reset_reset_n = 0 for 1 edge, keep key1 low.
  - Required: all outputs 0 at that edge; bit 1 rises 6 edges after reset release; field [23:20] = 1.
- Active-high variant, KEYS_ACTIVE_LOW=0:
  - Stimulus: key_in = 4'b0100 held.
  - Required: buttons_out = 32'h0100_0004 at edge 2+DEBOUNCE_CYCLES.
